// File: rtl/alu_cmd_issuer_pkg.sv
// alu_cmd_issuer_pkg: ALU opcodes and issuer FSM state encodings (package alu_pkg)
package alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command stream, ALU port and response stream of the issuer
interface alu_cmd_issuer_if #(parameter int N = 4);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic [1:0]   cmd_op;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [1:0]   rsp_op;
    logic         rsp_err;
    logic         busy;
    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err, busy
    );
    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err, busy
    );
endinterface

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO with wrap-bit pointers holding queued ALU commands
module cmd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    // pointer update; full blocks push even when a pop happens on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    // storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them, waits ALU_LAT, returns results in order (optional ALU_CHECK_EN)
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 0
) (
    input logic             clk,
    input logic             rst,
    alu_cmd_issuer_if.master bus
);
    localparam int W  = 2*N + 2;
    localparam int CW = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
    state_t       state;
    state_t       state_nxt;
    logic [CW-1:0] cnt;
    logic         full;
    logic         empty;
    logic         pop;
    logic         sample;
    logic         release_rsp;
    logic [W-1:0] head;
    logic [N-1:0] alu_a_q;
    logic [N-1:0] alu_b_q;
    logic [1:0]   alu_op_q;
    logic [N-1:0] rsp_result_q;
    logic [1:0]   rsp_op_q;
    cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.cmd_valid && !full),
        .pop     (pop),
        .wr_data ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );
    assign bus.cmd_ready  = !full;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = state == S_HOLD;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.busy       = state != S_IDLE || !empty;
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end
    // next state: issue from FIFO, sample when the latency count expires, release on handshake
    always_comb begin
        pop         = state == S_IDLE && !empty;
        sample      = state == S_WAIT && cnt == '0;
        release_rsp = state == S_HOLD && bus.rsp_ready;
        state_nxt   = pop ? S_WAIT : sample ? S_HOLD : release_rsp ? S_IDLE : state;
    end
    // ALU operand registers hold between issues; latency counter; response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            cnt          <= '0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
        end else begin
            if (pop) begin
                alu_op_q <= head[W-1 -: 2];
                alu_a_q  <= head[2*N-1 -: N];
                alu_b_q  <= head[N-1:0];
                cnt      <= CW'(ALU_LAT);
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (sample) begin
                rsp_result_q <= bus.alu_result;
                rsp_op_q     <= alu_op_q;
            end
        end
    end
`ifdef ALU_CHECK_EN
    logic [N-1:0] expected;
    logic         err_q;
    // reference result of the issued command, mod 2^N
    always_comb begin
        expected = alu_op_q == OP_ADD ? alu_a_q + alu_b_q :
                   alu_op_q == OP_OR  ? alu_a_q | alu_b_q :
                   alu_op_q == OP_SUB ? alu_a_q - alu_b_q : alu_a_q ^ alu_b_q;
    end
    // mismatch flag captured with the result and dropped with the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              err_q <= 1'b0;
        else if (sample)      err_q <= bus.alu_result != expected;
        else if (release_rsp) err_q <= 1'b0;
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed scoreboard bench for alu_cmd_issuer (ALU_LAT 0 and 2 instances)
module tb_alu_cmd_issuer;
    import alu_pkg::*;
    localparam int N = 4;
`ifdef ALU_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    alu_cmd_issuer_if #(.N(N)) i0 ();
    alu_cmd_issuer_if #(.N(N)) i1 ();
    alu_cmd_issuer #(.N(N), .DEPTH(4), .ALU_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(i0.master));
    alu_cmd_issuer #(.N(N), .DEPTH(4), .ALU_LAT(2)) dut1 (.clk(clk), .rst(rst), .bus(i1.master));
    logic         cv [2];
    logic [N-1:0] ca [2];
    logic [N-1:0] cb [2];
    logic [1:0]   cop [2];
    logic         rr [2];
    logic         cr [2];
    logic         rv [2];
    assign i0.cmd_valid = cv[0];
    assign i0.cmd_a     = ca[0];
    assign i0.cmd_b     = cb[0];
    assign i0.cmd_op    = cop[0];
    assign i0.rsp_ready = rr[0];
    assign i1.cmd_valid = cv[1];
    assign i1.cmd_a     = ca[1];
    assign i1.cmd_b     = cb[1];
    assign i1.cmd_op    = cop[1];
    assign i1.rsp_ready = rr[1];
    assign cr[0] = i0.cmd_ready;
    assign cr[1] = i1.cmd_ready;
    assign rv[0] = i0.rsp_valid;
    assign rv[1] = i1.rsp_valid;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic flip_or = 1'b0;
    int age1 = 100;
    logic [9:0] prev1 = '0;
    logic [6:0] sb0 [$];
    logic [6:0] sb1 [$];
    int tq [$];
    // bench ALU: OR optionally corrupts bit 0 to exercise the checker
    function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op, input logic fl);
        case (op)
            OP_ADD:  return a + b;
            OP_OR:   return (a | b) ^ {{(N-1){1'b0}}, fl};
            OP_SUB:  return a - b;
            default: return a ^ b;
        endcase
    endfunction
    assign i0.alu_result = alu_f(i0.alu_a, i0.alu_b, i0.alu_op, flip_or);
    assign i1.alu_result = age1 >= 2 ? alu_f(i1.alu_a, i1.alu_b, i1.alu_op, flip_or) : 'x;
    always @(posedge clk) cyc++;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // scoreboard monitor and ALU-delay age tracker for the latency-2 instance
    always @(negedge clk) begin
        logic [6:0] e;
        if ({i1.alu_op, i1.alu_a, i1.alu_b} != prev1) begin
            prev1 = {i1.alu_op, i1.alu_a, i1.alu_b};
            age1 = 0;
        end else if (age1 < 100) age1++;
        if (i0.rsp_valid && i0.rsp_ready) begin
            if (sb0.size() == 0) chk("spurious_rsp0", i0.rsp_valid, 0);
            else begin
                e = sb0.pop_front();
                chk("rsp0_result", i0.rsp_result, e[3:0]);
                chk("rsp0_op", i0.rsp_op, e[5:4]);
                chk("rsp0_err", i0.rsp_err, e[6]);
                tq.push_back(cyc);
            end
        end
        if (i1.rsp_valid && i1.rsp_ready) begin
            if (sb1.size() == 0) chk("spurious_rsp1", i1.rsp_valid, 0);
            else begin
                e = sb1.pop_front();
                chk("rsp1_result", i1.rsp_result, e[3:0]);
                chk("rsp1_op", i1.rsp_op, e[5:4]);
                chk("rsp1_err", i1.rsp_err, e[6]);
            end
        end
    end
    task automatic push(input int d, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [3:0] res, input logic err, output bit ok, output int e0);
        ca[d] = a;
        cb[d] = b;
        cop[d] = op;
        cv[d] = 1'b1;
        ok = 1'b0;
        e0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cr[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            e0 = cyc;
            if (d == 0) sb0.push_back({err, op, res});
            else        sb1.push_back({err, op, res});
            cv[d] = 1'b0;
        end else begin
            cv[d] = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_rsp(input int d, input int e0, input int lat, input string tag);
        int lat_seen = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv[d]) begin
                lat_seen = cyc - e0;
                break;
            end
        end
        chk(tag, lat_seen, 2 + lat);
    endtask
    task automatic drain(input string tag);
        for (int i = 0; i < 100 && (sb0.size() + sb1.size()) != 0; i++) @(negedge clk);
        chk(tag, sb0.size() + sb1.size(), 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        bit ok;
        int e0;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bit ok;
        int e0;
        bit seen;
        for (int d = 0; d < 2; d++) begin
            cv[d] = 1'b0; ca[d] = '0; cb[d] = '0; cop[d] = '0; rr[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", i0.cmd_ready, 1);
        chk("reset_busy", i0.busy, 0);
        chk("reset_rsp_valid", i0.rsp_valid, 0);
        chk("reset_alu", {i0.alu_op, i0.alu_a, i0.alu_b}, 0);
        chk("reset_rsp", {i0.rsp_err, i0.rsp_op, i0.rsp_result}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // wrap on add and borrow on sub, latency E0+2
        push(0, 4'hA, 4'h7, OP_ADD, 4'h1, 1'b0, ok, e0);
        wait_rsp(0, e0, 0, "lat0_add");
        drain("drain_add");
        push(0, 4'h3, 4'h5, OP_SUB, 4'hE, 1'b0, ok, e0);
        wait_rsp(0, e0, 0, "lat0_sub");
        drain("drain_sub");
        push(0, 4'hC, 4'hA, OP_OR, 4'hE, 1'b0, ok, e0);
        push(0, 4'hC, 4'hA, OP_XOR, 4'h6, 1'b0, ok, e0);
        drain("drain_ops");
        // back-to-back stream: in order, one response every 3 cycles
        tq.delete();
        push(0, 4'h1, 4'h2, OP_ADD, 4'h3, 1'b0, ok, e0);
        push(0, 4'hF, 4'h0, OP_OR, 4'hF, 1'b0, ok, e0);
        push(0, 4'h2, 4'h3, OP_SUB, 4'hF, 1'b0, ok, e0);
        push(0, 4'h5, 4'h5, OP_XOR, 4'h0, 1'b0, ok, e0);
        drain("drain_b2b");
        chk("b2b_count", tq.size(), 4);
        for (int i = 1; i < tq.size(); i++) chk($sformatf("b2b_spacing%0d", i), tq[i] - tq[i-1], 3);
        // backpressure: DEPTH queued plus one in flight
        rr[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(0, 4'(i), 4'h1, OP_ADD, 4'(i + 1), 1'b0, ok, e0);
            chk($sformatf("bp_accept%0d", i), ok, i < 5);
        end
        chk("bp_cmd_ready_low", i0.cmd_ready, 0);
        chk("bp_busy", i0.busy, 1);
        rr[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i0.cmd_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_ready_back", seen, 1);
        drain("drain_bp");
        // latency-2 ALU: X until settled, response at E0+4, operands held
        push(1, 4'h9, 4'h4, OP_ADD, 4'hD, 1'b0, ok, e0);
        wait_rsp(1, e0, 2, "lat2_add");
        chk("lat2_alu_hold", {i1.alu_op, i1.alu_a, i1.alu_b}, {OP_ADD, 4'h9, 4'h4});
        drain("drain_lat2a");
        push(1, 4'h6, 4'h9, OP_SUB, 4'hD, 1'b0, ok, e0);
        wait_rsp(1, e0, 2, "lat2_sub");
        drain("drain_lat2b");
        // reset while the latency-2 engine waits with two commands queued
        push(1, 4'h1, 4'h1, OP_ADD, 4'h2, 1'b0, ok, e0);
        push(1, 4'h2, 4'h2, OP_XOR, 4'h0, 1'b0, ok, e0);
        push(1, 4'h3, 4'h3, OP_ADD, 4'h6, 1'b0, ok, e0);
        chk("pre_rst_busy", i1.busy, 1);
        rst = 1'b1;
        sb0.delete();
        sb1.delete();
        #1;
        chk("rst_rsp_valid", i1.rsp_valid, 0);
        chk("rst_busy", i1.busy, 0);
        chk("rst_alu", {i1.alu_op, i1.alu_a, i1.alu_b}, 0);
        chk("rst_rsp", {i1.rsp_err, i1.rsp_op, i1.rsp_result}, 0);
        chk("rst_cmd_ready", i1.cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i1.rsp_valid) seen = 1'b1;
        end
        chk("rst_no_rsp", seen, 0);
        chk("rst_cmd_ready_after", i1.cmd_ready, 1);
        @(posedge clk);
        #1;
        // corrupted OR result passes through unchanged; flagged only with the checker
        flip_or = 1'b1;
        push(0, 4'hC, 4'hA, OP_OR, 4'hF, CHK, ok, e0);
        push(0, 4'h1, 4'h2, OP_ADD, 4'h3, 1'b0, ok, e0);
        drain("drain_err");
        flip_or = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
